commit_stage: RTL

Two-wide in-order retirement stage directly downstream of the reorder buffer. Each cycle it inspects the two oldest ROB entries, decides how many retire, and returns `commit_req_o` to the ROB so it can advance its tail. Retired results go to the architectural register file; retired stores release one store-buffer entry. On a mispredicted branch or an exception it raises the pipeline-wide flush with a redirect PC.

---
 rtl/commit_stage.sv | 138 +++++++++++++
 1 files changed

// File: rtl/commit_stage.sv
// commit_stage: two-wide in-order retirement out of the ROB.
// Decides how many of the two oldest entries retire, drives the ARF and
// store-buffer release, and sequences mispredict / exception flushes.
// Optional macro COMMIT_PERF_CNT_EN adds retired-instruction and flush counters.
module commit_stage #(
    parameter logic [31:0] EENTRY = 32'h1C00_0000
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [1:0]       rob_valid_i,
    input  logic [1:0][4:0]  rob_areg_i,
    input  logic [1:0]       rob_w_reg_i,
    input  logic [1:0]       rob_w_mem_i,
    input  logic [1:0][31:0] rob_data_i,
    input  logic [1:0][31:0] rob_pc_i,
    input  logic [1:0]       rob_exc_i,
    input  logic [1:0]       rob_mispred_i,
    input  logic [1:0][31:0] rob_target_i,
    output logic [1:0]       commit_req_o,
    output logic [1:0]       arf_we_o,
    output logic [1:0][4:0]  arf_waddr_o,
    output logic [1:0][31:0] arf_wdata_o,
    output logic             sb_commit_o,
    input  logic             sb_ready_i,
    input  logic             sb_empty_i,
    output logic             flush_o,
    output logic [31:0]      redirect_pc_o,
`ifdef COMMIT_PERF_CNT_EN
    output logic [31:0]      perf_inst_cnt_o,
    output logic [31:0]      perf_flush_cnt_o,
`endif
    output logic [31:0]      era_o
);

    typedef enum logic [1:0] {RUN, DRAIN, FLUSH} state_t;

    state_t      state;
    logic [31:0] pend_pc;
    logic        c0, c1, mis, exc, we0, we1;
    logic [31:0] mis_tgt, exc_pc;

    // Retire decision: slot 1 only follows a retiring, non-mispredicting slot 0,
    // and at most one store is released per cycle. Gated off while in reset.
    always_comb begin
        c0 = (state == RUN) && !rst && rob_valid_i[0] && !rob_exc_i[0] &&
             (!rob_w_mem_i[0] || sb_ready_i);
        c1 = c0 && rob_valid_i[1] && !rob_exc_i[1] && !rob_mispred_i[0] &&
             !(rob_w_mem_i[0] && rob_w_mem_i[1]) &&
             (!rob_w_mem_i[1] || sb_ready_i);
        commit_req_o = {c1, c0};
        sb_commit_o  = (c0 && rob_w_mem_i[0]) || (c1 && rob_w_mem_i[1]);
        mis     = (c0 && rob_mispred_i[0]) || (c1 && rob_mispred_i[1]);
        mis_tgt = (c0 && rob_mispred_i[0]) ? rob_target_i[0] : rob_target_i[1];
        // Exception candidate is the oldest valid entry that does not retire.
        exc     = (state == RUN) && !rst &&
                  ((rob_valid_i[0] && rob_exc_i[0]) ||
                   (c0 && !rob_mispred_i[0] && rob_valid_i[1] && rob_exc_i[1]));
        exc_pc  = (rob_valid_i[0] && rob_exc_i[0]) ? rob_pc_i[0] : rob_pc_i[1];
        we1 = c1 && rob_w_reg_i[1] && (rob_areg_i[1] != 5'd0);
        // Younger write wins when both target the same register.
        we0 = c0 && rob_w_reg_i[0] && (rob_areg_i[0] != 5'd0) &&
              !(we1 && (rob_areg_i[0] == rob_areg_i[1]));
    end

    // Flush sequencing FSM; flush_o/redirect_pc_o are registered on entry to FLUSH.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state         <= RUN;
            pend_pc       <= 32'd0;
            flush_o       <= 1'b0;
            redirect_pc_o <= 32'd0;
            era_o         <= 32'd0;
        end else begin
            flush_o <= 1'b0;
            case (state)
                RUN: begin
                    if (mis) begin
                        state         <= FLUSH;
                        pend_pc       <= mis_tgt;
                        flush_o       <= 1'b1;
                        redirect_pc_o <= mis_tgt;
                    end else if (exc) begin
                        era_o   <= exc_pc;
                        pend_pc <= EENTRY;
                        if (sb_empty_i) begin
                            state         <= FLUSH;
                            flush_o       <= 1'b1;
                            redirect_pc_o <= EENTRY;
                        end else begin
                            state <= DRAIN;
                        end
                    end
                end
                DRAIN: begin
                    if (sb_empty_i) begin
                        state         <= FLUSH;
                        flush_o       <= 1'b1;
                        redirect_pc_o <= pend_pc;
                    end
                end
                default: state <= RUN;
            endcase
        end
    end

    // ARF write port registers; address/data only update on a real write.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            arf_we_o    <= 2'b00;
            arf_waddr_o <= '0;
            arf_wdata_o <= '0;
        end else begin
            arf_we_o <= {we1, we0};
            if (we0) begin
                arf_waddr_o[0] <= rob_areg_i[0];
                arf_wdata_o[0] <= rob_data_i[0];
            end
            if (we1) begin
                arf_waddr_o[1] <= rob_areg_i[1];
                arf_wdata_o[1] <= rob_data_i[1];
            end
        end
    end

`ifdef COMMIT_PERF_CNT_EN
    // Retired-instruction and flush-pulse counters, wrapping at 2^32.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            perf_inst_cnt_o  <= 32'd0;
            perf_flush_cnt_o <= 32'd0;
        end else begin
            perf_inst_cnt_o  <= perf_inst_cnt_o + {31'd0, c0} + {31'd0, c1};
            perf_flush_cnt_o <= perf_flush_cnt_o + {31'd0, flush_o};
        end
    end
`endif

endmodule
